// File: rtl/result_accumulator_if.sv
// Valid/ready bundle carrying adder result pairs into the accumulator and
// frame totals out of it; slave is the accumulator, master is its environment.
interface result_accumulator_if #(
    parameter int IN_W  = 6,
    parameter int CNT_W = 4
);
    localparam int ACC_W = IN_W + 1 + CNT_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  result1;
    logic [IN_W-1:0]  result2;
    logic [CNT_W-1:0] frame_len;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [IN_W:0]    out_max;

    modport slave (
        input  in_valid, result1, result2, frame_len, out_ready,
        output in_ready, out_valid, out_sum, out_max
    );

    modport master (
        output in_valid, result1, result2, frame_len, out_ready,
        input  in_ready, out_valid, out_sum, out_max
    );
endinterface

// File: rtl/result_accumulator.sv
// Sums (result1+result2) pairs over a frame of programmable length, tracks the
// largest pair sum, and holds both on a registered output until accepted.
module result_accumulator #(
    parameter int IN_W  = 6,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    result_accumulator_if.slave bus
);
    localparam int ACC_W = IN_W + 1 + CNT_W;
    localparam int SUM_W = IN_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    function automatic logic [SUM_W-1:0] pair_sum(input logic [IN_W-1:0] a,
                                                  input logic [IN_W-1:0] b);
        return SUM_W'(a) + SUM_W'(b);
    endfunction

    function automatic logic [SUM_W-1:0] max_of(input logic [SUM_W-1:0] cur,
                                                input logic [SUM_W-1:0] s);
        return (s > cur) ? s : cur;
    endfunction

    // ACC_W leaves room for 2^CNT_W-1 full-scale pair sums, so this never wraps.
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                                 input logic [SUM_W-1:0] s);
        return acc + ACC_W'(s);
    endfunction

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [ACC_W-1:0] osum_q, osum_d;
    logic [SUM_W-1:0] omax_q, omax_d;
    logic [SUM_W-1:0] s;

    assign s = pair_sum(bus.result1, bus.result2);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        osum_d  = osum_q;
        omax_d  = omax_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    len_d = (bus.frame_len == '0) ? CNT_W'(1) : bus.frame_len;
                    acc_d = ACC_W'(s);
                    max_d = s;
                    cnt_d = CNT_W'(1);
                    // Lengths 0 and 1 both complete on this single beat.
                    if (bus.frame_len <= CNT_W'(1)) begin
                        osum_d  = ACC_W'(s);
                        omax_d  = s;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = acc_add(acc_q, s);
                    max_d = max_of(max_q, s);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == len_q) begin
                        osum_d  = acc_d;
                        omax_d  = max_d;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            osum_q  <= '0;
            omax_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            osum_q  <= osum_d;
            omax_q  <= omax_d;
        end
    end

    assign bus.in_ready  = (state_q != S_DONE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_sum   = osum_q;
    assign bus.out_max   = omax_q;
endmodule

// File: tb/tb_result_accumulator.sv
// Bench for result_accumulator: fixed frame table, backpressure and reset
// sequences, then random frames against a plain-arithmetic frame model.
module tb_result_accumulator;
    localparam int IN_W  = 6;
    localparam int CNT_W = 4;

    typedef struct packed {
        int               len;
        int               n;
        logic [14:0][5:0] a;
        logic [14:0][5:0] b;
        int               maxgap;
        int               exp_sum;
        int               exp_max;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t tbl[4];

    result_accumulator_if #(.IN_W(IN_W), .CNT_W(CNT_W)) bus ();

    result_accumulator #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: the frame result follows directly from the list of pairs.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   tot;
        int   mx;
        r   = v;
        r.n = (v.len == 0) ? 1 : v.len;
        tot = 0;
        mx  = 0;
        for (int i = 0; i < r.n; i++) begin
            tot += int'(v.a[i]) + int'(v.b[i]);
            if (int'(v.a[i]) + int'(v.b[i]) > mx) mx = int'(v.a[i]) + int'(v.b[i]);
        end
        r.exp_sum = tot;
        r.exp_max = mx;
        return r;
    endfunction

    task automatic send_frame(input vec_t v, input string nm);
        int w;
        for (int i = 0; i < v.n; i++) begin
            int g;
            g = (v.maxgap > 0) ? int'($urandom_range(0, v.maxgap)) : 0;
            bus.in_valid = 1'b0;
            repeat (g) tick();
            bus.in_valid  = 1'b1;
            bus.result1   = v.a[i];
            bus.result2   = v.b[i];
            bus.frame_len = (i == 0) ? v.len[3:0] : ~v.len[3:0];
            w = 0;
            while (!bus.in_ready && w < 50) begin
                tick();
                w++;
            end
            chk($sformatf("%s_ready_beat%0d", nm, i), bus.in_ready, 1);
            tick();
            if (i < v.n - 1) chk($sformatf("%s_early_valid%0d", nm, i), bus.out_valid, 0);
        end
        bus.in_valid = 1'b0;
        chk($sformatf("%s_out_valid", nm), bus.out_valid, 1);
        chk($sformatf("%s_in_ready_low", nm), bus.in_ready, 0);
        chk($sformatf("%s_out_sum", nm), bus.out_sum, v.exp_sum);
        chk($sformatf("%s_out_max", nm), bus.out_max, v.exp_max);
    endtask

    task automatic release_out(input int rd, input string nm);
        bus.out_ready = 1'b0;
        repeat (rd) begin
            tick();
            chk($sformatf("%s_hold_valid", nm), bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk($sformatf("%s_released_valid", nm), bus.out_valid, 0);
        chk($sformatf("%s_released_ready", nm), bus.in_ready, 1);
    endtask

    initial begin
        vec_t v;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.result1   = '0;
        bus.result2   = '0;
        bus.frame_len = '0;
        bus.out_ready = 1'b0;

        tbl[0] = '0;
        tbl[0].len = 3; tbl[0].n = 3; tbl[0].exp_sum = 75; tbl[0].exp_max = 62;
        tbl[0].a[0] = 6'd5;  tbl[0].b[0] = 6'd7;
        tbl[0].a[1] = 6'd31; tbl[0].b[1] = 6'd31;
        tbl[0].a[2] = 6'd0;  tbl[0].b[2] = 6'd1;
        tbl[1] = '0;
        tbl[1].len = 0; tbl[1].n = 1; tbl[1].exp_sum = 30; tbl[1].exp_max = 30;
        tbl[1].a[0] = 6'd10; tbl[1].b[0] = 6'd20;
        tbl[2] = '0;
        tbl[2].len = 15; tbl[2].n = 15; tbl[2].maxgap = 3;
        tbl[2].exp_sum = 1890; tbl[2].exp_max = 126;
        for (int i = 0; i < 15; i++) begin
            tbl[2].a[i] = 6'd63;
            tbl[2].b[i] = 6'd63;
        end
        tbl[3] = '0;
        tbl[3].len = 4; tbl[3].n = 4; tbl[3].maxgap = 1; tbl[3].exp_sum = 37; tbl[3].exp_max = 16;
        tbl[3].a[0] = 6'd8;  tbl[3].b[0] = 6'd8;
        tbl[3].a[1] = 6'd16; tbl[3].b[1] = 6'd0;
        tbl[3].a[2] = 6'd3;  tbl[3].b[2] = 6'd2;
        tbl[3].a[3] = 6'd0;  tbl[3].b[3] = 6'd0;

        repeat (3) tick();
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_sum", bus.out_sum, 0);
        chk("reset_out_max", bus.out_max, 0);
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 4; t++) begin
            send_frame(tbl[t], $sformatf("tbl%0d", t));
            release_out(0, $sformatf("tbl%0d", t));
        end

        // Backpressure: a pending result blocks new beats until accepted.
        send_frame(tbl[0], "bp_frame");
        bus.in_valid  = 1'b1;
        bus.result1   = 6'd3;
        bus.result2   = 6'd4;
        bus.frame_len = 4'd1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp_in_ready%0d", c), bus.in_ready, 0);
            chk($sformatf("bp_out_sum%0d", c), bus.out_sum, 75);
            chk($sformatf("bp_out_max%0d", c), bus.out_max, 62);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_ready", bus.in_ready, 1);
        chk("bp_release_sum_kept", bus.out_sum, 75);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_next_valid", bus.out_valid, 1);
        chk("bp_next_sum", bus.out_sum, 7);
        chk("bp_next_max", bus.out_max, 7);

        // Asynchronous reset while a result is pending.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_done_out_valid", bus.out_valid, 0);
        chk("rst_done_in_ready", bus.in_ready, 1);
        chk("rst_done_out_sum", bus.out_sum, 0);
        chk("rst_done_out_max", bus.out_max, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-frame; the next frame must carry no residue.
        bus.in_valid  = 1'b1;
        bus.frame_len = 4'd4;
        bus.result1   = 6'd9;
        bus.result2   = 6'd9;
        tick();
        bus.result1   = 6'd50;
        bus.result2   = 6'd50;
        tick();
        bus.in_valid  = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", bus.out_valid, 0);
        chk("rst_mid_in_ready", bus.in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        v = '0;
        v.len = 2; v.n = 2; v.exp_sum = 10; v.exp_max = 7;
        v.a[0] = 6'd1; v.b[0] = 6'd2;
        v.a[1] = 6'd3; v.b[1] = 6'd4;
        send_frame(v, "post_rst");
        release_out(1, "post_rst");

        for (int f = 0; f < 25; f++) begin
            v = '0;
            v.len    = int'($urandom_range(0, 15));
            v.maxgap = 2;
            for (int i = 0; i < 15; i++) begin
                v.a[i] = 6'($urandom_range(0, 63));
                v.b[i] = 6'($urandom_range(0, 63));
            end
            v = model(v);
            send_frame(v, $sformatf("rnd%0d", f));
            release_out(int'($urandom_range(0, 3)), $sformatf("rnd%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_accumulator.md
# result_accumulator

Downstream consumer of the dual-adder stage. Accepts (result1, result2) pairs over a valid/ready handshake and sums each pair. It accumulates a frame of a programmable number of pair sums and tracks the largest pair sum in the frame. It presents the frame total and the maximum on a registered valid/ready output port.

## Interface
- IN_W, 6, width of each incoming adder result
- CNT_W, 4, width of frame_len; the maximum frame is 2^CNT_W-1 pairs
- ACC_W, derived localparam = IN_W+1+CNT_W (11 at defaults), width of out_sum; overflow is impossible by construction
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  result1/result2/frame_len are valid
- in_ready  out  1  block can accept a pair
- result1  in  IN_W  first adder result, unsigned
- result2  in  IN_W  second adder result, unsigned
- frame_len  in  CNT_W  pairs per frame; sampled only on the first beat of a frame; 0 is treated as 1
- out_valid  out  1  frame result available
- out_ready  in  1  downstream accepts the frame result
- out_sum  out  ACC_W  sum over the frame of (result1+result2), unsigned
- out_max  out  IN_W+1  largest (result1+result2) in the frame

## Operation
- Beat accepted when in_valid & in_ready on a rising edge. Pair sum s = result1+result2, computed at IN_W+1 bits with no truncation.
- FSM states: IDLE, ACCUM, DONE. in_ready = (state != DONE).
- IDLE, on an accepted beat:
  - latch L = (frame_len==0) ? 1 : frame_len
  - acc <= s, max <= s, cnt <= 1
  - go to DONE if L==1, else go to ACCUM
- ACCUM, on an accepted beat:
  - acc <= acc+s; max <= (s>max) ? s : max; cnt <= cnt+1
  - if cnt+1==L: load out_sum/out_max from the updated values and go to DONE
  - no accepted beat (in_valid low): hold all state; gaps inside a frame are legal
- Entering DONE from IDLE (L==1): out_sum <= s, out_max <= s.
- DONE: out_valid=1, in_ready=0. When out_ready=1, go to IDLE and set out_valid <= 0. out_sum and out_max keep their values until the next frame completes.
- frame_len changes in mid-frame are ignored; only the latched L is used.
- A ties-equal pair sum leaves max unchanged; the value is identical either way.
- in_valid while in_ready=0 has no effect. Data is not captured, and upstream must hold it.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_max=0, internal acc/max/cnt/L=0.
- Reset mid-frame or mid-DONE discards the partial frame or pending result. The first beat after release starts a new frame.
- Latency: last beat accepted at edge k, so out_valid=1 and final out_sum/out_max are visible after edge k. out_ready=1 sampled at edge k+1 at the earliest.
- The DONE-to-IDLE handshake completes on the edge where out_valid & out_ready. in_ready rises after that edge, and the next frame's first beat is accepted no earlier than the following edge. This gives a minimum of one bubble cycle between frames.
- Throughput inside a frame: one pair per cycle.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset: hold rst_n=0 mid-stream -> out_valid=0, out_sum=0, out_max=0, in_ready=1 immediately and without waiting for a clock edge.
- Basic frame: frame_len=3, pairs (5,7),(31,31),(0,1) back-to-back -> out_sum=75, out_max=62, out_valid high after third accept edge, in_ready=0 until out_ready.
- Length 0 as 1 and a 1-beat frame: frame_len=0, pair (10,20) -> DONE after one beat, out_sum=30, out_max=30.
- Max width: frame_len=15, fifteen pairs (63,63) with random in_valid gaps -> out_sum=1890, out_max=126, no wrap. Change frame_len to 2 during the frame -> no effect.
- Backpressure: result pending, out_ready=0 for 5 cycles while in_valid=1 with new data -> no beat accepted, out_sum/out_max stable. out_ready=1 -> IDLE, next beat accepted one edge later.
- Reset mid-frame: frame_len=4, two beats accepted, pulse rst_n low, then frame_len=2, pairs (1,2),(3,4) -> out_sum=10, out_max=7, with no residue from the aborted frame.
